fsm_eg_driver: RTL and testbench

Stimulus transmitter for the two-input example FSM. Accepts an 8-bit command word over a valid/ready handshake and drives it onto the FSM's `a`/`b` inputs as four 2-bit symbols. It samples the FSM's `y1` (Moore) and `y0` (Mealy) outputs once per symbol and returns them as an 8-bit response word with a one-cycle valid strobe. It sits between a host/sequencer and the FSM's `a, b, y0, y1` pins.

---
 rtl/fsm_eg_driver.sv | 134 +++++++++++++
 tb/tb_fsm_eg_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_eg_driver.sv
// -----------------------------------------------------------------------------
// fsm_eg_driver
//
// Stimulus transmitter for the two-input example FSM. A command word accepted
// over a valid/ready handshake is played onto the FSM inputs a/b as four 2-bit
// symbols (symbol 0 = din[7:6]), each held for HOLD clock cycles. The FSM's
// Moore output y1 and Mealy output y0 are sampled in the last cycle of every
// symbol and returned as resp = {y1 samples, y0 samples} with a one-cycle
// resp_valid strobe; symbol 0's samples land in bits 7 and 3.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   din         command word, four {a,b} symbols, MSB pair first
//   din_valid   command word present
//   din_ready   block can accept a word (high only in IDLE)
//   a, b        registered drive to the FSM inputs
//   y0, y1      FSM Mealy / Moore outputs
//   resp        {y1_hist[3:0], y0_hist[3:0]}, held until the next completion
//   resp_valid  one-cycle strobe marking a new resp
//
// Parameter:
//   HOLD        clock cycles each symbol is held on a/b (must be >= 1)
// -----------------------------------------------------------------------------
module fsm_eg_driver #(
  parameter int HOLD = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       a,
  output logic       b,
  input  logic       y0,
  input  logic       y1,
  output logic [7:0] resp,
  output logic       resp_valid
);

  localparam int                HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Symbol 0 goes straight onto a/b at the accept edge, so only the three
  // remaining symbols need to be kept.
  logic [5:0]        sym_rest;
  logic [1:0]        sym_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        ab;

  // Only three samples are ever kept: the fourth goes straight into resp on
  // the completing edge together with the three older ones.
  logic [2:0]        y1_hist;
  logic [2:0]        y0_hist;

  logic              accept;
  logic              sample;
  logic              last_sym;

  assign accept   = (state == IDLE) && din_valid;
  assign sample   = (state == SEND) && (hold_cnt == HOLD_LAST);
  assign last_sym = (sym_cnt == 2'd3);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (din_valid)           state_nxt = SEND;
      SEND:    if (sample && last_sym)  state_nxt = DONE;
      DONE:                             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    din_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    a          = ab[1];
    b          = ab[0];
  end

  // Symbol shifter, hold/symbol counters, output histories
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ab       <= '0;
      sym_rest <= '0;
      sym_cnt  <= '0;
      hold_cnt <= '0;
      y1_hist  <= '0;
      y0_hist  <= '0;
      resp     <= '0;
    end else if (accept) begin
      ab       <= din[7:6];
      sym_rest <= din[5:0];
      sym_cnt  <= '0;
      hold_cnt <= '0;
    end else if (sample) begin
      // y0/y1 here are the FSM's response to the symbol driven this cycle.
      y1_hist  <= {y1_hist[1:0], y1};
      y0_hist  <= {y0_hist[1:0], y0};
      sym_rest <= {sym_rest[3:0], 2'b00};
      sym_cnt  <= sym_cnt + 2'd1;
      hold_cnt <= '0;
      if (last_sym) begin
        ab   <= '0;
        resp <= {y1_hist, y1, y0_hist, y0};
      end else begin
        ab   <= sym_rest[5:4];
      end
    end else if (state == SEND) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_fsm_eg_driver.sv
// -----------------------------------------------------------------------------
// Bench for fsm_eg_driver. Two instances (HOLD=1 and HOLD=3) each talk to a
// small two-state example FSM:
//   s0: y1=1, y0=a&b, goes to s1 on ab=11, else stays
//   s1: y1=0, y0=0,   always returns to s0
// A transaction-level model tracks, per instance, the number of edges since
// the accepted word and derives the expected a/b, handshake and response.
// -----------------------------------------------------------------------------
module tb_fsm_eg_driver;

  localparam int H0 = 1;
  localparam int H1 = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] din [2];
  logic [1:0] din_valid;
  logic [1:0] din_ready;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] y0;
  logic [1:0] y1;
  logic [7:0] resp [2];
  logic [1:0] resp_valid;

  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  fsm_eg_driver #(.HOLD(H0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .a(a[0]), .b(b[0]), .y0(y0[0]), .y1(y1[0]),
    .resp(resp[0]), .resp_valid(resp_valid[0])
  );

  fsm_eg_driver #(.HOLD(H1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .a(a[1]), .b(b[1]), .y0(y0[1]), .y1(y1[1]),
    .resp(resp[1]), .resp_valid(resp_valid[1])
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Example FSM environment, one per instance (bit i).
  logic [1:0] fsm_st;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsm_st <= '0;
    else          fsm_st <= ~fsm_st & a & b;
  end
  assign y1 = ~fsm_st;
  assign y0 = ~fsm_st & a & b;

  function automatic int hold_of(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  // Transaction model: m_t counts edges since the accept edge.
  logic       m_busy [2];
  int         m_t    [2];
  logic [7:0] m_word [2];
  logic [7:0] m_resp [2];
  logic [2:0] m_y1h  [2];
  logic [2:0] m_y0h  [2];

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_busy[i] <= 1'b0;
        m_t[i]    <= 0;
        m_word[i] <= '0;
        m_resp[i] <= '0;
        m_y1h[i]  <= '0;
        m_y0h[i]  <= '0;
      end else if (m_busy[i]) begin
        if (m_t[i] < 4 * hold_of(i) && ((m_t[i] + 1) % hold_of(i)) == 0) begin
          m_y1h[i] <= {m_y1h[i][1:0], y1[i]};
          m_y0h[i] <= {m_y0h[i][1:0], y0[i]};
        end
        m_t[i] <= m_t[i] + 1;
        if (m_t[i] + 1 == 4 * hold_of(i))
          m_resp[i] <= {m_y1h[i], y1[i], m_y0h[i], y0[i]};
        if (m_t[i] + 1 == 4 * hold_of(i) + 1)
          m_busy[i] <= 1'b0;
      end else if (din_valid[i]) begin
        m_busy[i] <= 1'b1;
        m_t[i]    <= 0;
        m_word[i] <= din[i];
      end
    end
  end

  // Response log filled by the per-cycle compare.
  int         n_resp    [2];
  logic [7:0] last_resp [2];
  logic [7:0] prev_resp [2];
  int         last_cyc  [2];
  int         prev_cyc  [2];
  int         acc_cyc   [2];

  task automatic chk(input string name, input int i, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", name, i, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] e_ab;
    for (int i = 0; i < 2; i++) begin
      e_ab = 2'b00;
      if (m_busy[i] && m_t[i] < 4 * hold_of(i))
        e_ab = m_word[i][7 - 2 * (m_t[i] / hold_of(i)) -: 2];
      chk("din_ready", i, {7'd0, din_ready[i]}, {7'd0, !m_busy[i]});
      chk("resp_valid", i, {7'd0, resp_valid[i]},
          {7'd0, (m_busy[i] && m_t[i] == 4 * hold_of(i))});
      chk("ab", i, {6'd0, a[i], b[i]}, {6'd0, e_ab});
      chk("resp", i, resp[i], m_resp[i]);
      if (resp_valid[i] === 1'b1) begin
        n_resp[i]++;
        prev_resp[i] = last_resp[i];
        prev_cyc[i]  = last_cyc[i];
        last_resp[i] = resp[i];
        last_cyc[i]  = cyc;
      end
    end
  endtask

  // Compare at the falling edge, then return 2 time units after the rising edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int i, input logic [7:0] w);
    din[i]       = w;
    din_valid[i] = 1'b1;
    step();
    acc_cyc[i]   = cyc;
    din_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, input int n, input int budget);
    for (int k = 0; k < budget && n_resp[i] < n; k++) step();
    chk("wait_resp", i, {7'd0, (n_resp[i] >= n)}, 8'd1);
  endtask

  int base;

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_resp[i] = 0; last_resp[i] = '0; prev_resp[i] = '0;
      last_cyc[i] = 0; prev_cyc[i] = 0; acc_cyc[i] = 0; din[i] = '0;
    end
    reset_n   = 1'b0;
    din_valid = '0;

    // Reset state
    repeat (3) step();
    chk("rst_ready", 0, {6'd0, din_ready}, 8'h03);
    chk("rst_valid", 0, {6'd0, resp_valid}, 8'h00);
    chk("rst_ab", 0, {4'd0, a, b}, 8'h00);
    reset_n = 1'b1;
    repeat (3) step();
    chk("rel_resp", 0, resp[0], 8'h00);

    // HOLD=1, 0xC0 from s0
    send(0, 8'hC0);
    chk("c0_sym0", 0, {6'd0, a[0], b[0]}, 8'h03);
    step();
    chk("c0_sym1", 0, {6'd0, a[0], b[0]}, 8'h00);
    wait_resp(0, 1, 20);
    chk("c0_resp", 0, last_resp[0], 8'hB8);
    chk("c0_lat", 0, 8'(last_cyc[0] - acc_cyc[0]), 8'd4);
    repeat (2) step();

    // HOLD=1, 0x88 from s0
    send(0, 8'h88);
    wait_resp(0, 2, 20);
    chk("88_resp", 0, last_resp[0], 8'hF0);
    repeat (2) step();

    // Back-to-back 0xC0 with din_valid held, then a pulse during SEND
    base         = n_resp[0];
    din[0]       = 8'hC0;
    din_valid[0] = 1'b1;
    repeat (7) step();
    din_valid[0] = 1'b0;
    step();
    din[0]       = 8'hFF;
    din_valid[0] = 1'b1;
    step();
    din_valid[0] = 1'b0;
    repeat (12) step();
    chk("b2b_count", 0, 8'(n_resp[0] - base), 8'd2);
    chk("b2b_resp1", 0, prev_resp[0], 8'hB8);
    chk("b2b_resp2", 0, last_resp[0], 8'hB8);
    chk("b2b_gap", 0, 8'(last_cyc[0] - prev_cyc[0]), 8'd6);

    // HOLD=3, 0x00
    send(1, 8'h00);
    wait_resp(1, 1, 40);
    chk("h3_resp", 1, last_resp[1], 8'hF0);
    chk("h3_lat", 1, 8'(last_cyc[1] - acc_cyc[1]), 8'd12);
    repeat (2) step();

    // Reset in the middle of a word on both instances
    din[0]    = 8'hC0;
    din[1]    = 8'hC0;
    din_valid = 2'b11;
    step();
    din_valid = 2'b00;
    repeat (2) step();
    chk("pre_rst_ab1", 1, {6'd0, a[1], b[1]}, 8'h03);
    base    = n_resp[0];
    reset_n = 1'b0;
    #1;
    chk("async_ab", 0, {4'd0, a, b}, 8'h00);
    chk("async_resp0", 0, resp[0], 8'h00);
    chk("async_resp1", 1, resp[1], 8'h00);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (6) step();
    chk("rst_no_resp", 0, 8'(n_resp[0] - base), 8'd0);
    send(0, 8'h88);
    wait_resp(0, base + 1, 20);
    chk("post_rst_resp", 0, last_resp[0], 8'hF0);

    // Random traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 2; i++) begin
        din[i]       = 8'($urandom);
        din_valid[i] = ($urandom_range(0, 2) != 0);
      end
      reset_n = ($urandom_range(0, 149) != 0);
      step();
    end
    reset_n   = 1'b1;
    din_valid = '0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
